// File: rtl/rr_mux_n.sv
// -----------------------------------------------------------------------------
// rr_mux_n
// N-channel, WIDTH-bit registered multiplexer with a valid/ready handshake on
// every input channel and on the single output stage. The source channel is
// picked either by a round-robin search or by an external fixed select.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset (deassertion expected to be
//              synchronised to clk by the reset generator)
//   in_data    packed channel words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel "word present"
//   in_ready   per-channel "word accepted this cycle" (combinational)
//   mode       0 = round-robin, 1 = fixed select
//   fix_sel    channel index used when mode = 1
//   out_data   registered selected word
//   out_sel    index of the channel that supplied out_data
//   out_valid  out_data holds a word
//   out_ready  consumer accepts out_data
//   xfer_cnt   (only with RR_MUX_N_CNT_EN) 16-bit saturating accepted-word
//              counter per channel, channel i at [i*16 +: 16]
//
// Build option
//   `define RR_MUX_N_CNT_EN adds the xfer_cnt port and its counters.
// -----------------------------------------------------------------------------
module rr_mux_n #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int SELW  = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         in_valid,
    output logic [N_CH-1:0]         in_ready,
    input  logic                    mode,
    input  logic [SELW-1:0]         fix_sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SELW-1:0]         out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef RR_MUX_N_CNT_EN
    ,
    output logic [N_CH*16-1:0]      xfer_cnt
`endif
);

    logic [SELW-1:0]  ptr_r;
    logic [WIDTH-1:0] out_data_r;
    logic [SELW-1:0]  out_sel_r;
    logic             out_valid_r;

    logic             load_s;
    logic             rr_grant_s;
    logic [SELW-1:0]  rr_idx_s;
    logic             fx_grant_s;
    logic [SELW-1:0]  fx_idx_s;
    logic             grant_s;
    logic [SELW-1:0]  gnt_idx_s;
    logic [SELW-1:0]  ptr_next_s;
    logic [WIDTH-1:0] sel_data_s;

    // The output stage can take a new word when it is empty or being drained.
    assign load_s = !out_valid_r || out_ready;

    // Round-robin search starting at ptr_r and wrapping at N_CH (which need not
    // be a power of two, so the wrap is an explicit compare, not a bit mask).
    always_comb begin
        int  cand_i;
        logic hit_s;
        rr_grant_s = 1'b0;
        rr_idx_s   = {SELW{1'b0}};
        cand_i     = 0;
        hit_s      = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            cand_i     = int'(ptr_r) + k;
            cand_i     = (cand_i >= N_CH) ? (cand_i - N_CH) : cand_i;
            hit_s      = !rr_grant_s && in_valid[SELW'(cand_i)];
            rr_grant_s = rr_grant_s | hit_s;
            rr_idx_s   = hit_s ? SELW'(cand_i) : rr_idx_s;
        end
    end

    // Fixed select: only an in-range index with a valid word can be granted,
    // so an out-of-range fix_sel simply never matches any channel.
    always_comb begin
        logic hit_s;
        fx_grant_s = 1'b0;
        fx_idx_s   = {SELW{1'b0}};
        hit_s      = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            hit_s      = (fix_sel == SELW'(i)) && in_valid[i];
            fx_grant_s = fx_grant_s | hit_s;
            fx_idx_s   = hit_s ? SELW'(i) : fx_idx_s;
        end
    end

    // Mode selects which search result is used; mode changes act immediately.
    assign grant_s    = mode ? fx_grant_s : rr_grant_s;
    assign gnt_idx_s  = mode ? fx_idx_s   : rr_idx_s;
    assign ptr_next_s = (gnt_idx_s == SELW'(N_CH - 1)) ? {SELW{1'b0}}
                                                       : (gnt_idx_s + SELW'(1));

    // Data mux and one-hot ready; ready is gated by load so backpressure
    // holds every producer.
    always_comb begin
        sel_data_s = {WIDTH{1'b0}};
        in_ready   = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            sel_data_s  = (gnt_idx_s == SELW'(i)) ? in_data[i*WIDTH +: WIDTH] : sel_data_s;
            in_ready[i] = load_s && grant_s && (gnt_idx_s == SELW'(i));
        end
    end

    // Output register stage: load on grant, empty on a load cycle without
    // grant (keeping the last data/sel), hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= {WIDTH{1'b0}};
            out_sel_r   <= {SELW{1'b0}};
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            if (grant_s) begin
                out_data_r  <= sel_data_s;
                out_sel_r   <= gnt_idx_s;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    // Round-robin pointer: advances past the granted channel, only in
    // round-robin mode, and survives mode switches untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {SELW{1'b0}};
        end else if (load_s && grant_s && (mode == 1'b0)) begin
            ptr_r <= ptr_next_s;
        end
    end

    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;
    assign out_valid = out_valid_r;

`ifdef RR_MUX_N_CNT_EN
    logic [15:0] cnt_r [N_CH];

    // Per-channel accepted-word counters, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_r[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (in_valid[i] && in_ready[i] && (cnt_r[i] != 16'hFFFF)) begin
                    cnt_r[i] <= cnt_r[i] + 16'd1;
                end
            end
        end
    end

    // Pack counters onto the flat output port.
    always_comb begin
        xfer_cnt = {(N_CH*16){1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            xfer_cnt[i*16 +: 16] = cnt_r[i];
        end
    end
`endif

endmodule

// File: doc/rr_mux_n.md
Name: rr_mux_n

Overview:
Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshake. It is the next generation of the team's 4:1 combinational mux.
- Selects among channels by round-robin arbitration or by an externally fixed select.
- Registers the chosen word into a single output stage.
- Sits between multiple producers and one consumer on a shared datapath.

Parameters:
N_CH, 4, number of input channels (>=2, need not be a power of 2)
WIDTH, 8, data width per channel
SELW, $clog2(N_CH), select/grant index width (derived; do not override)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N_CH  channel i holds a word
in_ready  output  N_CH  channel i word accepted this cycle (combinational)
mode  input  1  0 = round-robin, 1 = fixed select
fix_sel  input  SELW  channel index used when mode=1
out_data  output  WIDTH  registered selected word
out_sel  output  SELW  index of channel that supplied out_data
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0.
- Reset is asserted asynchronously and released synchronously. Reset mid-operation discards any held word with no flush.
- load = !out_valid || out_ready, i.e. the output stage is empty or draining this cycle.
- Grant, round-robin (mode=0):
  - Search channels ptr, ptr+1, … , N_CH-1, 0, … , ptr-1.
  - The first one with in_valid=1 is granted (g).
  - No valid channel means no grant.
- Grant, fixed (mode=1):
  - g = fix_sel if fix_sel < N_CH and in_valid[fix_sel]=1; otherwise no grant.
  - fix_sel >= N_CH never grants.
  - ptr is not updated in fixed mode.
- in_ready[i] = load && grant && (i==g). At most one in_ready bit high per cycle. in_ready never depends on in_valid of other channels beyond the grant search.
- On a clock edge with load=1 and a grant:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - If mode=0: ptr <= (g==N_CH-1) ? 0 : g+1.
- On a clock edge with load=1 and no grant: out_valid <= 0; out_data and out_sel hold their last values.
- load=0 (out_valid=1, out_ready=0): all outputs hold, ptr holds, in_ready all 0 (backpressure).
- Latency: 1 cycle from in_valid&in_ready to out_valid.
- Throughput: 1 word/cycle when out_ready is held high.
- Fairness: with all channels continuously valid in mode=0, grants cycle 0,1,…,N_CH-1,0 with no channel starved.
- Mode change takes effect in the same cycle's grant search. ptr retains its value across mode switches.

Optional Feature:
- Macro RR_MUX_N_CNT_EN.
- Defined:
  - Adds output port xfer_cnt [N_CH*16], one 16-bit counter per channel.
  - Counter i increments on each cycle where in_valid[i]&&in_ready[i].
  - Saturates at 16'hFFFF with no wrap.
  - Cleared to 0 by rst_n.
- Undefined: port and counters absent; all other behaviour identical.

Test Plan:
- Reset: drive rst_n=0 mid-transfer with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 asynchronously; first grant after release is channel 0 when all valid.
- Round-robin fairness: N_CH=4, mode=0, all in_valid=1, in_data={8'h44,8'h33,8'h22,8'h11}, out_ready=1 -> out_sel 0,1,2,3,0 on consecutive cycles, out_data 11,22,33,44,11.
- Sparse requests: only in_valid=4'b1010 -> grants alternate 1,3,1,3; channels 0/2 never get in_ready.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> out_data/out_sel stable, in_ready=0; out_ready=1 -> next word loaded same edge.
- Fixed mode: mode=1, fix_sel=2, in_valid=4'b1111 -> out_sel=2 every cycle. in_valid[2]=0 -> out_valid drops to 0 after 1 cycle. fix_sel=5 with N_CH=5? (use N_CH=4, fix_sel out-of-range not possible, so run N_CH=5, fix_sel=7) -> no grant.
- RR_MUX_N_CNT_EN: 10 transfers on channel 1 -> xfer_cnt[31:16]=10. Force 70000 transfers -> counter reads 16'hFFFF.
